instr_fetch_ctrl: RTL and testbench

//   Control-unit sequencer that sits on the consumer side of the program counter: drives the PC clear/increment

---
 rtl/instr_fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Multi-cycle control sequencer: drives PC strobes, latches the instruction word,
// and issues data-memory / register-file / ALU controls per FETCH-DECODE-EXECUTE pass.
module instr_fetch_ctrl #(
    parameter int unsigned IW  = 16,
    parameter int unsigned DAW = 8,
    parameter int unsigned RAW = 4
) (
    input  logic           Clock,
    input  logic           ClrN,
    input  logic [IW-1:0]  IM_Data,
    output logic           PC_Clr,
    output logic           PC_Up,
    output logic [IW-1:0]  IR,
    output logic [DAW-1:0] D_Addr,
    output logic           D_Wr,
    output logic           RF_s,
    output logic [RAW-1:0] RF_W_Addr,
    output logic           RF_W_en,
    output logic [RAW-1:0] RF_Ra_Addr,
    output logic [RAW-1:0] RF_Rb_Addr,
    output logic [2:0]     ALU_s,
    output logic           Halted,
    output logic [3:0]     State
);

    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_STORE  = 4'd4,
        S_LOAD_A = 4'd5,
        S_LOAD_B = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ir_q;
    logic [3:0]    opcode;

    assign opcode = ir_q[IW-1 -: 4];
    assign IR     = ir_q;
    assign State  = state;

    // State register and instruction register (loaded at the end of FETCH)
    always_ff @(posedge Clock or negedge ClrN) begin
        if (!ClrN) begin
            state <= S_INIT;
            ir_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                ir_q <= IM_Data;
            end
        end
    end

    // Next-state and Moore output decode from state and IR only
    always_comb begin
        state_nxt  = S_INIT;
        PC_Clr     = 1'b0;
        PC_Up      = 1'b0;
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        ALU_s      = 3'd0;
        Halted     = 1'b0;

        case (state)
            S_INIT: begin
                PC_Clr    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                PC_Up     = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_STORE: state_nxt = S_STORE;
                    OP_LOAD:  state_nxt = S_LOAD_A;
                    OP_ADD:   state_nxt = S_ADD;
                    OP_SUB:   state_nxt = S_SUB;
                    OP_HALT:  state_nxt = S_HALT;
                    default:  state_nxt = S_NOOP;
                endcase
            end
            S_NOOP: begin
                state_nxt = S_FETCH;
            end
            S_STORE: begin
                D_Addr     = DAW'(ir_q[7:0]);
                RF_Ra_Addr = RAW'(ir_q[11:8]);
                D_Wr       = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_LOAD_A, S_LOAD_B: begin
                D_Addr    = DAW'(ir_q[11:4]);
                RF_s      = 1'b1;
                RF_W_Addr = RAW'(ir_q[3:0]);
                RF_W_en   = (state == S_LOAD_B);
                state_nxt = (state == S_LOAD_A) ? S_LOAD_B : S_FETCH;
            end
            S_ADD, S_SUB: begin
                RF_Ra_Addr = RAW'(ir_q[11:8]);
                RF_Rb_Addr = RAW'(ir_q[7:4]);
                RF_W_Addr  = RAW'(ir_q[3:0]);
                ALU_s      = (state == S_ADD) ? 3'd1 : 3'd2;
                RF_W_en    = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_HALT: begin
                Halted    = 1'b1;
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase

        // Strobes drop the moment reset asserts, even mid-instruction
        if (!ClrN) begin
            PC_Clr     = 1'b0;
            PC_Up      = 1'b0;
            D_Addr     = '0;
            D_Wr       = 1'b0;
            RF_s       = 1'b0;
            RF_W_Addr  = '0;
            RF_W_en    = 1'b0;
            RF_Ra_Addr = '0;
            RF_Rb_Addr = '0;
            ALU_s      = 3'd0;
            Halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a simple PC plus instruction memory around the DUT,
// with expected per-cycle controls derived from each instruction's cycle recipe.
module tb_instr_fetch_ctrl;

    logic        Clock;
    logic        ClrN;
    logic [15:0] IM_Data;
    logic        PC_Clr;
    logic        PC_Up;
    logic [15:0] IR;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s;
    logic        Halted;
    logic [3:0]  State;

    instr_fetch_ctrl #(.IW(16), .DAW(8), .RAW(4)) dut (
        .Clock      (Clock),
        .ClrN       (ClrN),
        .IM_Data    (IM_Data),
        .PC_Clr     (PC_Clr),
        .PC_Up      (PC_Up),
        .IR         (IR),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s      (ALU_s),
        .Halted     (Halted),
        .State      (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Environment: 7-bit program counter and 128-word instruction memory
    logic [15:0] imem [128];
    logic [6:0]  bench_pc;

    always_ff @(posedge Clock or negedge ClrN) begin
        if (!ClrN)       bench_pc <= 7'd0;
        else if (PC_Clr) bench_pc <= 7'd0;
        else if (PC_Up)  bench_pc <= bench_pc + 7'd1;
    end

    assign IM_Data = imem[bench_pc];

    int          checks = 0;
    int          errors = 0;
    int          exp_pc = 0;
    logic [15:0] cur_ir = 16'h0000;

    logic [44:0] act;
    assign act = {PC_Clr, PC_Up, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
                  RF_Ra_Addr, RF_Rb_Addr, ALU_s, Halted, IR};

    function automatic logic [44:0] ev(input logic pclr, input logic pup,
                                       input logic [7:0] da, input logic dwr,
                                       input logic rfs, input logic [3:0] rw,
                                       input logic wen, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [2:0] alu,
                                       input logic hlt, input logic [15:0] ir);
        return {pclr, pup, da, dwr, rfs, rw, wen, ra, rb, alu, hlt, ir};
    endfunction

    task automatic chk(input string tag, input logic [44:0] e);
        checks++;
        assert (act === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, e);
        end
    endtask

    task automatic step(input string tag, input logic [44:0] e);
        @(negedge Clock);
        chk(tag, e);
    endtask

    // Assert reset, confirm everything is quiet, release, expect one INIT cycle
    task automatic do_reset_pulse();
        ClrN = 1'b0;
        #1;
        chk("reset", ev(0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0, 16'h0000));
        @(posedge Clock);
        #2 ClrN = 1'b1;
        exp_pc = 0;
        cur_ir = 16'h0000;
        step("init", ev(1, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0, 16'h0000));
    endtask

    // One full instruction at the expected PC; optionally reset during LOAD_B
    task automatic exec_instr(input bit abort_load_b);
        logic [15:0] w;
        logic [3:0]  op;
        w = imem[exp_pc];
        step("fetch", ev(0, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0, cur_ir));
        exp_pc = (exp_pc + 1) % 128;
        cur_ir = w;
        op     = w[15:12];
        step("decode", ev(0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0, w));
        case (op)
            4'd1: step("store", ev(0, 0, w[7:0], 1, 0, 4'h0, 0, w[11:8], 4'h0, 3'd0, 0, w));
            4'd2: begin
                step("load_a", ev(0, 0, w[11:4], 0, 1, w[3:0], 0, 4'h0, 4'h0, 3'd0, 0, w));
                step("load_b", ev(0, 0, w[11:4], 0, 1, w[3:0], 1, 4'h0, 4'h0, 3'd0, 0, w));
                if (abort_load_b) do_reset_pulse();
            end
            4'd3: step("add", ev(0, 0, 8'h00, 0, 0, w[3:0], 1, w[11:8], w[7:4], 3'd1, 0, w));
            4'd4: step("sub", ev(0, 0, 8'h00, 0, 0, w[3:0], 1, w[11:8], w[7:4], 3'd2, 0, w));
            4'd5: repeat (25) step("halt", ev(0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 1, w));
            default: step("noop", ev(0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0, w));
        endcase
    endtask

    initial begin
        logic [4:0]  r;
        logic [3:0]  op;
        logic [11:0] fld;

        ClrN = 1'b1;
        imem[0] = 16'h21A3;
        imem[1] = 16'h3125;
        imem[2] = 16'h4125;
        imem[3] = 16'h170F;
        imem[4] = 16'hF000;
        for (int i = 5; i < 128; i++) begin
            r = 5'($urandom_range(0, 19));
            if (r > 5'd15) op = 4'(r - 5'd15);
            else           op = r[3:0];
            if (op == 4'd5) op = 4'd3;
            fld = 12'($urandom);
            imem[i] = {op, fld};
        end

        #1;
        do_reset_pulse();

        // Directed instructions, then random program running past the PC wrap
        for (int n = 0; n < 140; n++) exec_instr(1'b0);

        // HALT parks the sequencer until reset
        imem[exp_pc] = 16'h5000;
        exec_instr(1'b0);
        do_reset_pulse();

        // Address 0 holds a LOAD; reset lands during its LOAD_B cycle
        exec_instr(1'b1);
        for (int n = 0; n < 4; n++) exec_instr(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
